svc_rv_pipe_stage: RTL and testbench

Generic, parametrised RISC-V pipeline stage register. It is the successor to the fixed IF/ID PC register.
- Carries an arbitrary-width payload with valid/ready handshaking instead of a bare stall input.
- Implements flush by dropping held entries; the previous stage register ignored flush.
- Supports an optional 2-entry skid mode that removes the combinational ready path.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM) in svc_rv.

---
 rtl/svc_rv_pipe_pkg.sv | 33 +++
 rtl/svc_rv_pipe_skid.sv | 113 +++++++++++
 rtl/svc_rv_pipe_stage.sv | 111 +++++++++++
 tb/tb_svc_rv_pipe_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_pipe_pkg.sv
// Shared types, constants and helpers for the svc_rv pipeline stage register.
package svc_rv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int STAT_W = 32;

  // Number of entries held by the skid buffer in a given state.
  function automatic logic [1:0] occupancy(input pipe_state_t state);
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] base,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, base} + {{(STAT_W-1){1'b0}}, inc};
    if (sum[STAT_W]) begin
      sat_add = {STAT_W{1'b1}};
    end else begin
      sat_add = sum[STAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/svc_rv_pipe_skid.sv
// svc_rv_pipe_skid: two-entry skid buffer used by svc_rv_pipe_stage when SKID=1.
// s_ready is a flop, so there is no combinational path from m_ready to s_ready.
module svc_rv_pipe_skid
  import svc_rv_pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       drop_num
);

  pipe_state_t      state_r;
  pipe_state_t      state_nxt_s;
  logic             s_ready_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             load_main_s;
  logic             load_skid_s;
  logic             move_skid_s;

  assign s_ready    = s_ready_r;
  assign m_valid    = (state_r != EMPTY);
  assign m_data     = main_r;
  assign in_xfer_s  = s_valid && s_ready_r;
  assign out_xfer_s = m_valid && m_ready;

  // Next state, payload load strobes and the number of entries lost to a flush
  always_comb begin
    state_nxt_s = state_r;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    move_skid_s = 1'b0;
    drop_num    = 2'd0;
    if (flush) begin
      // A same-cycle output transfer was delivered, so it is not a drop.
      state_nxt_s = EMPTY;
      drop_num    = occupancy(state_r) + {1'b0, in_xfer_s} - {1'b0, out_xfer_s};
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = ONE;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s = ONE;
            load_main_s = 1'b1;
          end else if (in_xfer_s) begin
            state_nxt_s = FULL;
            load_skid_s = 1'b1;
          end else if (out_xfer_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          if (out_xfer_s) begin
            state_nxt_s = ONE;
            move_skid_s = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state and its registered ready decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      s_ready_r <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      s_ready_r <= (state_nxt_s != FULL);
    end
  end

  // Payload storage; contents are meaningless unless the state says otherwise
  always_ff @(posedge clk) begin
    if (load_main_s) begin
      main_r <= s_data;
    end else if (move_skid_s) begin
      main_r <= skid_r;
    end else begin
      main_r <= main_r;
    end
    if (load_skid_s) begin
      skid_r <= s_data;
    end else begin
      skid_r <= skid_r;
    end
  end

endmodule

// File: rtl/svc_rv_pipe_stage.sv
// svc_rv_pipe_stage: valid/ready pipeline register (passthrough, single entry or skid).
// Optional saturating stall/drop counters when SVC_RV_PIPE_STAGE_STATS_EN is defined.
module svc_rv_pipe_stage
  import svc_rv_pipe_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int PIPELINED = 1,
  parameter int SKID      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  logic [1:0] drop_num_s;

  if (PIPELINED == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst_n, flush};
    assign m_valid     = s_valid;
    assign m_data      = s_data;
    assign s_ready     = m_ready;
    assign drop_num_s  = 2'd0;
  end else if (SKID == 0) begin : g_reg
    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             in_xfer_s;
    logic             out_xfer_s;

    assign s_ready    = !valid_r || m_ready;
    assign m_valid    = valid_r;
    assign m_data     = data_r;
    assign in_xfer_s  = s_valid && s_ready;
    assign out_xfer_s = valid_r && m_ready;
    assign drop_num_s = flush ? ({1'b0, valid_r} + {1'b0, in_xfer_s} - {1'b0, out_xfer_s})
                              : 2'd0;

    // Entry valid flag: flush beats any load
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
      end else if (flush) begin
        valid_r <= 1'b0;
      end else if (in_xfer_s) begin
        valid_r <= 1'b1;
      end else if (out_xfer_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end

    // Payload register, not reset
    always_ff @(posedge clk) begin
      if (in_xfer_s) begin
        data_r <= s_data;
      end else begin
        data_r <= data_r;
      end
    end
  end else begin : g_skid
    svc_rv_pipe_skid #(
      .WIDTH(WIDTH)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .drop_num(drop_num_s)
    );
  end

`ifdef SVC_RV_PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_r;
  logic [STAT_W-1:0] drop_cnt_r;

  // Saturating stall and drop counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {STAT_W{1'b0}};
      drop_cnt_r  <= {STAT_W{1'b0}};
    end else begin
      stall_cnt_r <= sat_add(stall_cnt_r, {1'b0, m_valid && !m_ready});
      drop_cnt_r  <= sat_add(drop_cnt_r, drop_num_s);
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign drop_cnt  = drop_cnt_r;
`else
  logic unused_stats;
  assign unused_stats = ^drop_num_s;
`endif

endmodule

// File: tb/tb_svc_rv_pipe_stage.sv
// Self-checking bench for svc_rv_pipe_stage: passthrough, single-entry and skid instances.
module tb_svc_rv_pipe_stage;
  import svc_rv_pipe_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;

  logic pt_flush, pt_s_valid, pt_s_ready, pt_m_valid, pt_m_ready;
  logic [W-1:0] pt_s_data, pt_m_data;
  logic r_flush, r_s_valid, r_s_ready, r_m_valid, r_m_ready;
  logic [W-1:0] r_s_data, r_m_data;
  logic k_flush, k_s_valid, k_s_ready, k_m_valid, k_m_ready;
  logic [W-1:0] k_s_data, k_m_data;
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
  logic [31:0] pt_stall, pt_drop, r_stall, r_drop, k_stall, k_drop;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] rq[$];
  logic [W-1:0] kq[$];
  int r_exp_drop = 0;
  int k_exp_drop = 0;

  always #5 clk = ~clk;

  svc_rv_pipe_stage #(.WIDTH(W), .PIPELINED(0), .SKID(0)) u_pt (
    .clk(clk), .rst_n(rst_n), .flush(pt_flush),
    .s_valid(pt_s_valid), .s_ready(pt_s_ready), .s_data(pt_s_data),
    .m_valid(pt_m_valid), .m_ready(pt_m_ready), .m_data(pt_m_data)
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    , .stall_cnt(pt_stall), .drop_cnt(pt_drop)
`endif
  );

  svc_rv_pipe_stage #(.WIDTH(W), .PIPELINED(1), .SKID(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(r_flush),
    .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data),
    .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data)
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    , .stall_cnt(r_stall), .drop_cnt(r_drop)
`endif
  );

  svc_rv_pipe_stage #(.WIDTH(W), .PIPELINED(1), .SKID(1)) u_skd (
    .clk(clk), .rst_n(rst_n), .flush(k_flush),
    .s_valid(k_s_valid), .s_ready(k_s_ready), .s_data(k_s_data),
    .m_valid(k_m_valid), .m_ready(k_m_ready), .m_data(k_m_data)
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    , .stall_cnt(k_stall), .drop_cnt(k_drop)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (r_m_valid !== 1'b0) begin n_err++; $display("FAIL rst_r_mvalid: got %b want 0", r_m_valid); end
    n_cmp++; if (r_s_ready !== 1'b1) begin n_err++; $display("FAIL rst_r_sready: got %b want 1", r_s_ready); end
    n_cmp++; if (k_m_valid !== 1'b0) begin n_err++; $display("FAIL rst_k_mvalid: got %b want 0", k_m_valid); end
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL rst_k_sready: got %b want 1", k_s_ready); end
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (k_stall !== 32'd0) begin n_err++; $display("FAIL rst_k_stall: got %0d want 0", k_stall); end
    n_cmp++; if (k_drop !== 32'd0) begin n_err++; $display("FAIL rst_k_drop: got %0d want 0", k_drop); end
`endif
  endtask

  task automatic test_passthrough();
    pt_s_valid = 1'b1; pt_s_data = 16'h1234; pt_m_ready = 1'b1;
    #1;
    n_cmp++; if (pt_m_valid !== 1'b1) begin n_err++; $display("FAIL pt_mvalid: got %b want 1", pt_m_valid); end
    n_cmp++; if (pt_m_data !== 16'h1234) begin n_err++; $display("FAIL pt_mdata: got %h want 1234", pt_m_data); end
    n_cmp++; if (pt_s_ready !== 1'b1) begin n_err++; $display("FAIL pt_sready_hi: got %b want 1", pt_s_ready); end
    pt_m_ready = 1'b0;
    #1;
    n_cmp++; if (pt_s_ready !== 1'b0) begin n_err++; $display("FAIL pt_sready_lo: got %b want 0", pt_s_ready); end
    pt_s_valid = 1'b0;
    #1;
    n_cmp++; if (pt_m_valid !== 1'b0) begin n_err++; $display("FAIL pt_mvalid_lo: got %b want 0", pt_m_valid); end
  endtask

  task automatic test_streaming();
    logic exp_mv;
    logic [W-1:0] exp;
    r_m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      r_s_valid = (i < 3);
      r_s_data  = 16'h0010 + 16'(i);
      @(negedge clk);
      if (r_s_valid && r_s_ready) rq.push_back(r_s_data);
      exp_mv = (i >= 1 && i <= 3);
      n_cmp++; if (r_s_ready !== 1'b1) begin n_err++; $display("FAIL stream_sready[%0d]: got %b want 1", i, r_s_ready); end
      n_cmp++; if (r_m_valid !== exp_mv) begin n_err++; $display("FAIL stream_mvalid[%0d]: got %b want %b", i, r_m_valid, exp_mv); end
      if (r_m_valid && r_m_ready && rq.size() > 0) begin
        exp = rq.pop_front();
        n_cmp++; if (r_m_data !== exp) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, r_m_data, exp); end
      end
    end
    r_s_valid = 1'b0;
    n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL stream_left: got %0d want 0", rq.size()); end
  endtask

  task automatic test_skid_stream();
    logic exp_mv;
    logic [W-1:0] exp;
    k_m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      k_s_valid = (i < 6);
      k_s_data  = 16'h0020 + 16'(i);
      @(negedge clk);
      if (k_s_valid && k_s_ready) kq.push_back(k_s_data);
      exp_mv = (i >= 1 && i <= 6);
      n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL kstream_sready[%0d]: got %b want 1", i, k_s_ready); end
      n_cmp++; if (k_m_valid !== exp_mv) begin n_err++; $display("FAIL kstream_mvalid[%0d]: got %b want %b", i, k_m_valid, exp_mv); end
      if (k_m_valid && k_m_ready && kq.size() > 0) begin
        exp = kq.pop_front();
        n_cmp++; if (k_m_data !== exp) begin n_err++; $display("FAIL kstream_data[%0d]: got %h want %h", i, k_m_data, exp); end
      end
    end
    k_s_valid = 1'b0;
    n_cmp++; if (kq.size() != 0) begin n_err++; $display("FAIL kstream_left: got %0d want 0", kq.size()); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    k_m_ready = 1'b0;
    tick(); k_s_valid = 1'b1; k_s_data = 16'h000A;
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL bp_sready0: got %b want 1", k_s_ready); end
    if (k_s_valid && k_s_ready) kq.push_back(k_s_data);
    tick(); k_s_data = 16'h000B;
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL bp_sready1: got %b want 1", k_s_ready); end
    n_cmp++; if (k_m_data !== 16'h000A) begin n_err++; $display("FAIL bp_head: got %h want 000a", k_m_data); end
    if (k_s_valid && k_s_ready) kq.push_back(k_s_data);
    tick(); k_s_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b want 0", k_s_ready); end
    n_cmp++; if (k_m_valid !== 1'b1) begin n_err++; $display("FAIL bp_mvalid: got %b want 1", k_m_valid); end
    tick(); k_m_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b0) begin n_err++; $display("FAIL bp_pop1_sready: got %b want 0", k_s_ready); end
    n_cmp++; if (k_m_valid !== 1'b1 || kq.size() == 0) begin n_err++; $display("FAIL bp_pop1_valid: got %b want 1", k_m_valid); end
    else begin
      exp = kq.pop_front();
      n_cmp++; if (k_m_data !== exp) begin n_err++; $display("FAIL bp_pop1_data: got %h want %h", k_m_data, exp); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop2_sready: got %b want 1", k_s_ready); end
    n_cmp++; if (k_m_valid !== 1'b1 || kq.size() == 0) begin n_err++; $display("FAIL bp_pop2_valid: got %b want 1", k_m_valid); end
    else begin
      exp = kq.pop_front();
      n_cmp++; if (k_m_data !== exp) begin n_err++; $display("FAIL bp_pop2_data: got %h want %h", k_m_data, exp); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (k_m_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", k_m_valid); end
    k_m_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [W-1:0] exp;
    // Skid FULL with A/B; flush with a pending input that FULL refuses.
    k_m_ready = 1'b0;
    tick(); k_s_valid = 1'b1; k_s_data = 16'h000A;
    tick(); k_s_data = 16'h000B;
    tick(); k_flush = 1'b1; k_s_data = 16'h000C;
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b0) begin n_err++; $display("FAIL fl_sready_full: got %b want 0", k_s_ready); end
    k_exp_drop += 2;
    tick(); k_flush = 1'b0; k_s_valid = 1'b0; k_m_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (k_m_valid !== 1'b0) begin n_err++; $display("FAIL fl_mvalid: got %b want 0", k_m_valid); end
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL fl_sready: got %b want 1", k_s_ready); end
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (k_drop !== 32'(k_exp_drop)) begin n_err++; $display("FAIL fl_drop_full: got %0d want %0d", k_drop, k_exp_drop); end
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (k_m_valid !== 1'b0) begin n_err++; $display("FAIL fl_ghost[%0d]: got %b data %h want 0", i, k_m_valid, k_m_data); end
    end
    // Skid ONE: flush while D is delivered and E is accepted then discarded.
    k_m_ready = 1'b0;
    tick(); k_s_valid = 1'b1; k_s_data = 16'h000D;
    @(negedge clk);
    if (k_s_valid && k_s_ready) kq.push_back(k_s_data);
    tick(); k_s_data = 16'h000E; k_m_ready = 1'b1; k_flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL fl1_sready: got %b want 1", k_s_ready); end
    n_cmp++; if (k_m_valid !== 1'b1 || kq.size() == 0) begin n_err++; $display("FAIL fl1_deliver: got %b want 1", k_m_valid); end
    else begin
      exp = kq.pop_front();
      n_cmp++; if (k_m_data !== exp) begin n_err++; $display("FAIL fl1_data: got %h want %h", k_m_data, exp); end
    end
    k_exp_drop += 1;
    tick(); k_flush = 1'b0; k_s_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (k_m_valid !== 1'b0) begin n_err++; $display("FAIL fl1_mvalid: got %b want 0", k_m_valid); end
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (k_drop !== 32'(k_exp_drop)) begin n_err++; $display("FAIL fl1_drop: got %0d want %0d", k_drop, k_exp_drop); end
`endif
    // Single-entry register holding F, flush with a refused input G.
    r_m_ready = 1'b0;
    tick(); r_s_valid = 1'b1; r_s_data = 16'h000F;
    tick(); r_s_data = 16'h0010; r_flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (r_s_ready !== 1'b0) begin n_err++; $display("FAIL flr_sready: got %b want 0", r_s_ready); end
    r_exp_drop += 1;
    tick(); r_flush = 1'b0; r_s_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (r_m_valid !== 1'b0) begin n_err++; $display("FAIL flr_mvalid: got %b want 0", r_m_valid); end
    n_cmp++; if (r_s_ready !== 1'b1) begin n_err++; $display("FAIL flr_sready_after: got %b want 1", r_s_ready); end
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (r_drop !== 32'(r_exp_drop)) begin n_err++; $display("FAIL flr_drop: got %0d want %0d", r_drop, r_exp_drop); end
`endif
    k_m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    k_m_ready = 1'b0; r_m_ready = 1'b0;
    tick(); k_s_valid = 1'b1; k_s_data = 16'h0055; r_s_valid = 1'b1; r_s_data = 16'h0066;
    tick(); k_s_valid = 1'b0; r_s_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (k_m_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_k: got %b want 1", k_m_valid); end
    n_cmp++; if (r_m_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_r: got %b want 1", r_m_valid); end
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    kq.delete(); rq.delete(); k_exp_drop = 0; r_exp_drop = 0;
    n_cmp++; if (k_m_valid !== 1'b0) begin n_err++; $display("FAIL rm_k_mvalid: got %b want 0", k_m_valid); end
    n_cmp++; if (k_s_ready !== 1'b1) begin n_err++; $display("FAIL rm_k_sready: got %b want 1", k_s_ready); end
    n_cmp++; if (r_m_valid !== 1'b0) begin n_err++; $display("FAIL rm_r_mvalid: got %b want 0", r_m_valid); end
    n_cmp++; if (r_s_ready !== 1'b1) begin n_err++; $display("FAIL rm_r_sready: got %b want 1", r_s_ready); end
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (k_stall !== 32'd0) begin n_err++; $display("FAIL rm_k_stall: got %0d want 0", k_stall); end
    n_cmp++; if (r_stall !== 32'd0) begin n_err++; $display("FAIL rm_r_stall: got %0d want 0", r_stall); end
    n_cmp++; if (k_drop !== 32'd0) begin n_err++; $display("FAIL rm_k_drop: got %0d want 0", k_drop); end
`endif
  endtask

  task automatic test_stall_counter();
    logic [W-1:0] exp;
    r_m_ready = 1'b0;
    tick(); r_s_valid = 1'b1; r_s_data = 16'h00D5;
    @(negedge clk);
    if (r_s_valid && r_s_ready) rq.push_back(r_s_data);
    tick(); r_s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (r_m_valid !== 1'b1) begin n_err++; $display("FAIL stall_mvalid[%0d]: got %b want 1", i, r_m_valid); end
      n_cmp++; if (r_m_data !== 16'h00D5) begin n_err++; $display("FAIL stall_hold[%0d]: got %h want 00d5", i, r_m_data); end
      tick();
    end
    @(negedge clk);
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (r_stall !== 32'd5) begin n_err++; $display("FAIL stall_cnt: got %0d want 5", r_stall); end
`endif
    r_m_ready = 1'b1;
    #1;
    n_cmp++; if (r_m_valid !== 1'b1 || rq.size() == 0) begin n_err++; $display("FAIL stall_release: got %b want 1", r_m_valid); end
    else begin
      exp = rq.pop_front();
      n_cmp++; if (r_m_data !== exp) begin n_err++; $display("FAIL stall_data: got %h want %h", r_m_data, exp); end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (r_m_valid !== 1'b0) begin n_err++; $display("FAIL stall_drained: got %b want 0", r_m_valid); end
`ifdef SVC_RV_PIPE_STAGE_STATS_EN
    n_cmp++; if (r_stall !== 32'd5) begin n_err++; $display("FAIL stall_cnt_after: got %0d want 5", r_stall); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    logic k_prev_stall, r_prev_stall;
    logic [W-1:0] k_prev_data, r_prev_data;
    k_prev_stall = 1'b0; r_prev_stall = 1'b0;
    k_prev_data = '0; r_prev_data = '0;
    for (int c = 0; c < 120; c++) begin
      tick();
      r_s_valid = ($urandom_range(0, 3) != 0); r_s_data = 16'($urandom);
      r_m_ready = ($urandom_range(0, 2) != 0);
      k_s_valid = ($urandom_range(0, 3) != 0); k_s_data = 16'($urandom);
      k_m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (r_prev_stall) begin
        n_cmp++; if (r_m_valid !== 1'b1 || r_m_data !== r_prev_data) begin n_err++; $display("FAIL b2b_r_hold[%0d]: got %b/%h want 1/%h", c, r_m_valid, r_m_data, r_prev_data); end
      end
      if (k_prev_stall) begin
        n_cmp++; if (k_m_valid !== 1'b1 || k_m_data !== k_prev_data) begin n_err++; $display("FAIL b2b_k_hold[%0d]: got %b/%h want 1/%h", c, k_m_valid, k_m_data, k_prev_data); end
      end
      if (r_s_valid && r_s_ready) rq.push_back(r_s_data);
      if (k_s_valid && k_s_ready) kq.push_back(k_s_data);
      if (r_m_valid && r_m_ready) begin
        n_cmp++;
        if (rq.size() == 0) begin n_err++; $display("FAIL b2b_r_extra[%0d]: got %h want none", c, r_m_data); end
        else begin exp = rq.pop_front(); if (r_m_data !== exp) begin n_err++; $display("FAIL b2b_r_data[%0d]: got %h want %h", c, r_m_data, exp); end end
      end
      if (k_m_valid && k_m_ready) begin
        n_cmp++;
        if (kq.size() == 0) begin n_err++; $display("FAIL b2b_k_extra[%0d]: got %h want none", c, k_m_data); end
        else begin exp = kq.pop_front(); if (k_m_data !== exp) begin n_err++; $display("FAIL b2b_k_data[%0d]: got %h want %h", c, k_m_data, exp); end end
      end
      r_prev_stall = r_m_valid && !r_m_ready; r_prev_data = r_m_data;
      k_prev_stall = k_m_valid && !k_m_ready; k_prev_data = k_m_data;
    end
    // Drain with a bounded budget.
    for (int c = 0; c < 8; c++) begin
      tick();
      r_s_valid = 1'b0; r_m_ready = 1'b1; k_s_valid = 1'b0; k_m_ready = 1'b1;
      @(negedge clk);
      if (r_m_valid && rq.size() > 0) begin
        exp = rq.pop_front();
        n_cmp++; if (r_m_data !== exp) begin n_err++; $display("FAIL drain_r_data: got %h want %h", r_m_data, exp); end
      end
      if (k_m_valid && kq.size() > 0) begin
        exp = kq.pop_front();
        n_cmp++; if (k_m_data !== exp) begin n_err++; $display("FAIL drain_k_data: got %h want %h", k_m_data, exp); end
      end
    end
    n_cmp++; if (rq.size() != 0 || r_m_valid !== 1'b0) begin n_err++; $display("FAIL drain_r: got %0d left valid %b want 0", rq.size(), r_m_valid); end
    n_cmp++; if (kq.size() != 0 || k_m_valid !== 1'b0) begin n_err++; $display("FAIL drain_k: got %0d left valid %b want 0", kq.size(), k_m_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    pt_flush = 1'b0; pt_s_valid = 1'b0; pt_s_data = '0; pt_m_ready = 1'b0;
    r_flush = 1'b0; r_s_valid = 1'b0; r_s_data = '0; r_m_ready = 1'b0;
    k_flush = 1'b0; k_s_valid = 1'b0; k_s_data = '0; k_m_ready = 1'b0;
    test_reset();
    test_passthrough();
    test_streaming();
    test_skid_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_stall_counter();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
